// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter, port 0 fixed priority with port-1 starvation guard
// Registers a one-cycle response per grant and flags word addresses beyond DEPTH.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_be,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,

    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_be,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,

    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);
    localparam logic [CNT_W-1:0]  LIMIT_W = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             sel1;
    logic             in_range0;
    logic             in_range1;

    assign in_range0 = (m0_addr >> 2) < DEPTH_W;
    assign in_range1 = (m1_addr >> 2) < DEPTH_W;
    assign starved   = (starve_cnt == LIMIT_W);

    // Grants are masked during reset so nothing reaches memory or the response path.
    assign sel1   = ~rst & m1_req & (~m0_req | starved);
    assign m1_gnt = sel1;
    assign m0_gnt = ~rst & m0_req & ~sel1;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (m1_gnt) begin
            mem_we    = m1_we & in_range1;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_be    = m1_be;
        end else if (m0_gnt) begin
            mem_we    = m0_we & in_range0;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_be    = m0_be;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m0_err    <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
            m1_err    <= 1'b0;
        end else begin
            m0_rvalid <= m0_gnt;
            m0_err    <= m0_gnt & ~in_range0;
            m0_rdata  <= (m0_gnt & ~m0_we & in_range0) ? mem_rdata : '0;
            m1_rvalid <= m1_gnt;
            m1_err    <= m1_gnt & ~in_range1;
            m1_rdata  <= (m1_gnt & ~m1_we & in_range1) ? mem_rdata : '0;
        end
    end

    // Count only while port 1 waits; a grant or a dropped request restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (m1_req & ~m1_gnt) begin
            if (!starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

`ifndef SYNTHESIS
    localparam int SNAP_W = 1 + ADDR_W + DATA_W + BE_W;

    logic              p0_pend;
    logic              p1_pend;
    logic [SNAP_W-1:0] p0_snap;
    logic [SNAP_W-1:0] p1_snap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_pend <= 1'b0;
            p1_pend <= 1'b0;
            p0_snap <= '0;
            p1_snap <= '0;
        end else begin
            p0_pend <= m0_req & ~m0_gnt;
            p1_pend <= m1_req & ~m1_gnt;
            p0_snap <= {m0_we, m0_addr, m0_wdata, m0_be};
            p1_snap <= {m1_we, m1_addr, m1_wdata, m1_be};
        end
    end

    // A waiting requester must hold its command fields until granted.
    always @(posedge clk) begin
        if (!rst && p0_pend && m0_req) begin
            assert ({m0_we, m0_addr, m0_wdata, m0_be} == p0_snap)
                else $error("port 0 command changed while waiting for grant");
        end
        if (!rst && p1_pend && m1_req) begin
            assert ({m1_we, m1_addr, m1_wdata, m1_be} == p1_snap)
                else $error("port 1 command changed while waiting for grant");
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a behavioural dataMem
module tb_dmem_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int DEPTH        = 1024;
    localparam int STARVE_LIMIT = 4;
    localparam int BE_W         = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [BE_W-1:0]   m0_be, m1_be;
    logic              m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata)
    );

    // dataMem: combinational read (0 while writing), byte-enabled write, be=0 writes the whole word
    assign mem_rdata = mem_we ? '0 :
                       (((mem_addr >> 2) < DEPTH) ? mem[mem_addr[11:2]] : '0);

    always @(posedge clk) begin
        if (mem_we && ((mem_addr >> 2) < DEPTH)) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_be == '0 || mem_be[b]) begin
                    mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    endtask

    task automatic test_reset;
        rst = 1;
        m0_req = 1; m0_we = 1; m0_addr = 32'h0; m0_wdata = 32'h12345678; m0_be = 4'hF;
        m1_req = 1; m1_we = 0; m1_addr = 32'h0;
        tick; tick;
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_we} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_we});
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", {m0_rdata, m1_rdata});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
            errors++;
            $display("FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata, mem_be});
        end
        clear_req;
        rst = 0;
        tick;
        checks++;
        if (mem[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_no_write: got %h expected 00000000", mem[0]);
        end
    endtask

    task automatic test_single;
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF; m0_be = 4'hF;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, mem_we, mem_addr} !== {3'b101, 32'h10}) begin
            errors++;
            $display("FAIL single_wr_gnt: got %b/%h expected 101/00000010",
                     {m0_gnt, m1_gnt, mem_we}, mem_addr);
        end
        tick;
        checks++;
        if ({m0_rvalid, m0_err, m0_rdata} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL single_wr_ack: got %b/%h expected 10/00000000", {m0_rvalid, m0_err}, m0_rdata);
        end
        m0_we = 0; m0_wdata = '0;
        #1;
        checks++;
        if ({m0_gnt, mem_we} !== 2'b10) begin
            errors++;
            $display("FAIL single_rd_gnt: got %b expected 10", {m0_gnt, mem_we});
        end
        tick;
        checks++;
        if ({m0_rvalid, m0_err, m0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_rd_data: got %b/%h expected 10/deadbeef", {m0_rvalid, m0_err}, m0_rdata);
        end
        m0_req = 0;
        tick;
        checks++;
        if (m0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_rvalid_drop: got %b expected 0", m0_rvalid);
        end
    endtask

    task automatic test_byte;
        m1_req = 1; m1_we = 1; m1_addr = 32'h10; m1_wdata = 32'h000000AA; m1_be = 4'b0001;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, mem_we, mem_be} !== 7'b0110001) begin
            errors++;
            $display("FAIL byte_wr_gnt: got %b expected 0110001", {m0_gnt, m1_gnt, mem_we, mem_be});
        end
        tick;
        m1_we = 0; m1_wdata = '0; m1_be = '0;
        tick;
        checks++;
        if ({m1_rvalid, m1_err, m1_rdata} !== {2'b10, 32'hDEADBEAA}) begin
            errors++;
            $display("FAIL byte_rd_data: got %b/%h expected 10/deadbeaa", {m1_rvalid, m1_err}, m1_rdata);
        end
        m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h11223344; m1_be = 4'b0000;
        tick;
        m1_we = 0; m1_wdata = '0;
        tick;
        checks++;
        if ({m1_rvalid, m1_rdata} !== {1'b1, 32'h11223344}) begin
            errors++;
            $display("FAIL be_zero_full_word: got %b/%h expected 1/11223344", m1_rvalid, m1_rdata);
        end
        clear_req;
        tick;
    endtask

    task automatic test_starve;
        logic e1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        #1;
        for (int i = 0; i < 10; i++) begin
            e1 = (i % 5 == 4);
            checks++;
            if ({m0_gnt, m1_gnt} !== {~e1, e1}) begin
                errors++;
                $display("FAIL starve_gnt[%0d]: got %b expected %b", i, {m0_gnt, m1_gnt}, {~e1, e1});
            end
            tick;
            checks++;
            if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !==
                {~e1, e1, (e1 ? 32'h0 : 32'hDEADBEAA), (e1 ? 32'h11223344 : 32'h0)}) begin
                errors++;
                $display("FAIL starve_resp[%0d]: got %b %h %h", i, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata);
            end
        end
        clear_req;
        tick;
    endtask

    task automatic test_range;
        m0_req = 1; m0_we = 0; m0_addr = DEPTH * 4;
        #1;
        checks++;
        if ({m0_gnt, mem_we} !== 2'b10) begin
            errors++;
            $display("FAIL range_rd_gnt: got %b expected 10", {m0_gnt, mem_we});
        end
        tick;
        checks++;
        if ({m0_rvalid, m0_err, m0_rdata} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL range_rd_err: got %b/%h expected 11/00000000", {m0_rvalid, m0_err}, m0_rdata);
        end
        m0_addr = (DEPTH - 1) * 4;
        tick;
        checks++;
        if ({m0_rvalid, m0_err} !== 2'b10) begin
            errors++;
            $display("FAIL range_last_word: got %b expected 10", {m0_rvalid, m0_err});
        end
        m0_req = 0;
        m1_req = 1; m1_we = 1; m1_addr = DEPTH * 4; m1_wdata = 32'hFFFFFFFF; m1_be = 4'hF;
        #1;
        checks++;
        if ({m1_gnt, mem_we} !== 2'b10) begin
            errors++;
            $display("FAIL range_wr_blocked: got %b expected 10", {m1_gnt, mem_we});
        end
        tick;
        checks++;
        if ({m1_rvalid, m1_err, m1_rdata} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL range_wr_err: got %b/%h expected 11/00000000", {m1_rvalid, m1_err}, m1_rdata);
        end
        checks++;
        if ({mem[0], mem[4], mem[DEPTH-1]} !== {32'h0, 32'hDEADBEAA, 32'h0}) begin
            errors++;
            $display("FAIL range_array: got %h %h %h", mem[0], mem[4], mem[DEPTH-1]);
        end
        clear_req;
        tick;
    endtask

    task automatic test_reset_mid;
        logic e1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        tick; tick;
        checks++;
        if ({m0_rvalid, dut.starve_cnt} !== {1'b1, 3'd2}) begin
            errors++;
            $display("FAIL mid_pre: got %b/%0d expected 1/2", m0_rvalid, dut.starve_cnt);
        end
        rst = 1;
        #1;
        checks++;
        if ({m0_rvalid, m0_gnt, m1_gnt, dut.starve_cnt} !== 6'b0) begin
            errors++;
            $display("FAIL mid_async_clear: got %b/%0d expected 000/0",
                     {m0_rvalid, m0_gnt, m1_gnt}, dut.starve_cnt);
        end
        tick;
        rst = 0;
        #1;
        for (int i = 0; i < 5; i++) begin
            e1 = (i == 4);
            checks++;
            if ({m0_gnt, m1_gnt} !== {~e1, e1}) begin
                errors++;
                $display("FAIL mid_resume[%0d]: got %b expected %b", i, {m0_gnt, m1_gnt}, {~e1, e1});
            end
            tick;
        end
        checks++;
        if ({m0_rvalid, m1_rvalid, m1_rdata} !== {2'b01, 32'h11223344}) begin
            errors++;
            $display("FAIL mid_resume_resp: got %b/%h expected 01/11223344", {m0_rvalid, m1_rvalid}, m1_rdata);
        end
        clear_req;
        tick;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        clear_req;
        test_reset;
        test_single;
        test_byte;
        test_starve;
        test_range;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
